// File: rtl/montgomery_pkg.sv
// Shared defaults, FSM state encoding and constants for the Montgomery exponentiation controller.
package montgomery_pkg;

  localparam int DEFAULT_WIDTH     = 1024;
  localparam int DEFAULT_EXP_WIDTH = 1024;

  // Operand B of the final product; multiplying by plain 1 leaves the Montgomery domain.
  localparam int MM_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TOMONT   = 3'd1,
    S_SQR      = 3'd2,
    S_MUL      = 3'd3,
    S_FROMMONT = 3'd4,
    S_FIN      = 3'd5
  } mexp_state_t;

endpackage

// File: rtl/mm_req_port.sv
// Requester side of the multiplier handshake: registers the start pulse and operands,
// then reports the cycle whose mm_done completes the outstanding product.
module mm_req_port
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             mm_done,
  input  logic [WIDTH:0]   mm_result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic             pending,
  output logic             cap,
  output logic [WIDTH-1:0] cap_data
);

  // Handshake: mm_start is high for exactly the issue cycle; mm_a/mm_b then stay frozen
  // until the first cycle after the issue cycle in which mm_done is high (the capture).
  logic waiting;
  logic mm_msb_unused;

  assign cap           = waiting && mm_done;
  assign pending       = mm_start || waiting;
  assign cap_data      = mm_result[WIDTH-1:0];
  assign mm_msb_unused = mm_result[WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mm_start <= 1'b0;
      waiting  <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
    end else begin
      mm_start <= req;
      if (req) begin
        mm_a <= req_a;
        mm_b <= req_b;
      end
      if (mm_start)
        waiting <= 1'b1;
      else if (cap)
        waiting <= 1'b0;
    end
  end

endmodule

// File: rtl/montgomery_exp_ctrl.sv
// Computes x^e mod m by sequencing Montgomery products (left-to-right square-and-multiply).
// Build option MONTEXP_SKIP_LEADING_EN skips the squarings ahead of the exponent's leading one.
module montgomery_exp_ctrl
  import montgomery_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r2,
  input  logic [WIDTH-1:0]     in_r,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH:0]       mm_result,
  input  logic                 mm_done,
  output logic [2:0]           dbg_state
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(EXP_WIDTH - 1);

  mexp_state_t          state, state_nx;
  logic [WIDTH-1:0]     acc, xm, m_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IW-1:0]        i;
  logic                 req, step, skip_sqr, pending, cap;
  logic [WIDTH-1:0]     req_a, req_b, cap_data;

`ifdef MONTEXP_SKIP_LEADING_EN
  logic started;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      started <= 1'b0;
    else if (state == S_IDLE)
      started <= 1'b0;
    else if (state_nx == S_MUL)
      started <= 1'b1;
  end
  assign skip_sqr = !started;
`else
  assign skip_sqr = 1'b0;
`endif

  mm_req_port #(.WIDTH(WIDTH)) u_port (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .mm_done   (mm_done),
    .mm_result (mm_result),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .pending   (pending),
    .cap       (cap),
    .cap_data  (cap_data)
  );

  // A product is requested the cycle before its issue cycle; TOMONT is requested straight
  // from IDLE so its operands come from the inputs rather than latched copies.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    req_a    = acc;
    req_b    = acc;
    step     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_TOMONT;
          req      = 1'b1;
          req_a    = in_x;
          req_b    = in_r2;
        end
      end
      S_TOMONT: if (cap) state_nx = S_SQR;
      S_SQR: begin
        if (skip_sqr || cap) begin
          if (e_q[i]) state_nx = S_MUL;
          else        step     = 1'b1;
        end else if (!pending) begin
          req = 1'b1;
        end
      end
      S_MUL: begin
        if (cap) step = 1'b1;
        else if (!pending) begin
          req   = 1'b1;
          req_b = xm;
        end
      end
      S_FROMMONT: begin
        if (cap) state_nx = S_FIN;
        else if (!pending) begin
          req   = 1'b1;
          req_b = WIDTH'(MM_ONE);
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (step) state_nx = (i == '0) ? S_FROMMONT : S_SQR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      acc    <= '0;
      xm     <= '0;
      m_q    <= '0;
      e_q    <= '0;
      i      <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        acc <= in_r;
        m_q <= in_m;
        e_q <= in_e;
        i   <= I_TOP;
      end
      if (cap) begin
        if (state == S_TOMONT) xm  <= cap_data;
        else                   acc <= cap_data;
      end
      // Writing result at the final capture makes it valid in the same cycle as done.
      if (cap && state == S_FROMMONT) result <= cap_data;
      if (step && i != '0) i <= i - 1'b1;
    end
  end

  assign mm_m      = m_q;
  assign done      = (state == S_FIN);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Bench for montgomery_exp_ctrl: behavioural Montgomery multiplier responder, scoreboard
// of expected results/product counts, and a golden modular-exponentiation reference.
module tb_montgomery_exp_ctrl;
  import montgomery_pkg::*;

  localparam int W  = 1024;
  localparam int EW = 1024;

  logic          clk, resetn, start;
  logic [W-1:0]  in_x, in_m, in_r2, in_r;
  logic [EW-1:0] in_e;
  logic [W-1:0]  result, mm_a, mm_b, mm_m;
  logic          done, busy, mm_start, mm_done;
  logic [W:0]    mm_result;
  logic [2:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int mm_lat = 1;
  bit glitch = 0;
  logic [W-1:0] exp_q[$];
  int cnt_q[$];

  montgomery_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r2(in_r2), .in_r(in_r),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  // golden reference: right-to-left binary exponentiation with plain modular arithmetic
  function automatic logic [W-1:0] pow_mod(input logic [W-1:0] x, input logic [EW-1:0] e,
                                            input logic [W-1:0] m);
    logic [2*W-1:0] acc, base, mm;
    mm = {{W{1'b0}}, m};
    acc = 1;
    acc = acc % mm;
    base = {{W{1'b0}}, x} % mm;
    for (int k = 0; k < EW; k++) begin
      if (e[k]) acc = (acc * base) % mm;
      base = (base * base) % mm;
    end
    return acc[W-1:0];
  endfunction

  // multiplier behaviour: a*b*2^-W mod m (REDC with Newton-derived -m^-1 mod 2^W)
  function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
    logic [W-1:0]   inv, mp, u;
    logic [2*W-1:0] t;
    logic [2*W:0]   s;
    logic [W:0]     res;
    inv = 1;
    for (int k = 0; k < 11; k++) inv = inv * (W'(2) - m * inv);
    mp  = -inv;
    t   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    u   = t[W-1:0] * mp;
    s   = {1'b0, t} + {{(W+1){1'b0}}, u} * {{(W+1){1'b0}}, m};
    res = s[2*W:W];
    if (res >= {1'b0, m}) res = res - {1'b0, m};
    return res[W-1:0];
  endfunction

  function automatic int exp_count(input logic [EW-1:0] e);
    int pc = 0;
    int msb = -1;
    for (int k = 0; k < EW; k++) if (e[k]) begin pc++; msb = k; end
`ifdef MONTEXP_SKIP_LEADING_EN
    return (msb < 0) ? 2 : 2 + msb + pc;
`else
    return 2 + EW + pc;
`endif
  endfunction

  // responder: one product per mm_start, result after mm_lat cycles, reset aborts it
  initial begin : responder
    logic [W-1:0] op_a, op_b, op_m, res;
    bit ok, alive;
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      if (resetn && mm_start) begin
        op_a = mm_a; op_b = mm_b; op_m = mm_m;
        ok = 1; alive = 1;
        res = mont_mul(op_a, op_b, op_m);
        if (glitch) begin mm_done = 1'b1; mm_result = '1; end
        for (int k = 1; k <= mm_lat && alive; k++) begin
          @(negedge clk);
          mm_done = 1'b0;
          if (!resetn) alive = 0;
          else begin
            if (mm_a !== op_a || mm_b !== op_b || mm_m !== op_m) ok = 0;
            if (k == mm_lat) begin
              mm_done = 1'b1;
              mm_result = {1'($urandom_range(0, 1)), res};
            end
          end
        end
        if (alive) begin
          check("operands_stable", W'(ok), W'(1));
          @(negedge clk);
          mm_done = 1'b0;
        end
      end
    end
  end

  // monitor: pops expectations on every done
  initial begin : monitor
    int mm_seen = 0;
    int c;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!resetn) mm_seen = 0;
      else begin
        if (mm_start) mm_seen++;
        if (done) begin
          if (exp_q.size() == 0) check("unexpected_done", W'(done), W'(0));
          else begin
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            check("result", result, e);
            check("mm_start_count", W'(mm_seen), W'(c));
            check("busy_at_done", W'(busy), W'(1));
          end
          mm_seen = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic start_run(input logic [W-1:0] x, input logic [EW-1:0] e,
                           input logic [W-1:0] m, input logic [W-1:0] expv);
    logic [2*W-1:0] big, mm, r;
    mm  = {{W{1'b0}}, m};
    big = 1;
    big = big << W;
    r   = big % mm;
    @(negedge clk);
    in_x = x; in_e = e; in_m = m; in_r = r[W-1:0];
    big = (r * r) % mm;
    in_r2 = big[W-1:0];
    start = 1'b1;
    exp_q.push_back(expv);
    cnt_q.push_back(exp_count(e));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int budget = exp_count(in_e) * (mm_lat + 3) + 200;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, W'(exp_q.size()), W'(0));
      exp_q.delete(); cnt_q.delete();
    end else begin
      @(negedge clk);
      check({name, "_idle_after"}, W'({busy, done}), W'(0));
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (dbg_state != s && n < budget) begin @(negedge clk); n++; end
    check(name, W'(dbg_state), W'(s));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, result, '0);
    check({tag, "_mm_a"}, mm_a, '0);
    check({tag, "_mm_b"}, mm_b, '0);
    check({tag, "_mm_m"}, mm_m, '0);
    check({tag, "_flags"}, W'({done, busy, mm_start}), W'(0));
    check({tag, "_state"}, W'(dbg_state), W'(S_IDLE));
  endtask

  task automatic random_run(input int lat, input string name);
    logic [W-1:0] m, x;
    logic [EW-1:0] e;
    for (int k = 0; k < W / 32; k++) begin
      m[k*32 +: 32] = $urandom;
      x[k*32 +: 32] = $urandom;
    end
    m[0] = 1'b1; m[W-1] = 1'b1; x[W-1] = 1'b0;
    e = '0;
    for (int k = 0; k < 100; k++) e[k] = 1'($urandom_range(0, 1));
    mm_lat = lat;
    start_run(x, e, m, pow_mod(x, e, m));
    wait_idle(name);
  endtask

  initial begin : driver
    resetn = 1'b0; start = 1'b0;
    in_x = '0; in_e = '0; in_m = '0; in_r2 = '0; in_r = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    start_run(W'(4), EW'(13), W'(497), W'(445));
    wait_idle("x4_e13");
    start_run(W'(123), EW'(0), W'(497), W'(1));
    wait_idle("e0");
    start_run(W'(496), EW'(1), W'(497), W'(496));
    wait_idle("e1");
    start_run(W'(123), '1, W'(497), pow_mod(W'(123), '1, W'(497)));
    wait_idle("e_all_ones");

    // start re-pulse in SQR plus mm_done pulses in every issue cycle
    glitch = 1;
    start_run(W'(4), EW'(13), W'(497), W'(445));
    wait_state(S_SQR, 100, "reach_sqr");
    in_x = W'(5); in_e = EW'(7); in_m = W'(499); in_r = W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("repulse");
    glitch = 0;
    repeat (5) @(negedge clk);

    // asynchronous reset in the middle of a MUL product
    start_run(W'(4), EW'(13), W'(497), W'(445));
    wait_state(S_MUL, 10000, "reach_mul");
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_zero("midrun_reset");
    exp_q.delete(); cnt_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_run(W'(4), EW'(13), W'(497), W'(445));
    wait_idle("after_reset");

    random_run(1, "rand_l1_a");
    random_run(1, "rand_l1_b");
    random_run(37, "rand_l37");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
